xor_result_monitor: RTL

XOR_RESULT_MONITOR -- requirements
Module: xor_result_monitor

---
 rtl/xor_mon_pkg.sv | 14 +
 rtl/sat_counter.sv | 21 ++
 rtl/xor_result_monitor.sv | 122 ++++++++++++
 3 files changed

// File: rtl/xor_mon_pkg.sv
// Shared types and constants for the XOR result monitor.
package xor_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_t;

  // Bit positions inside first_fail_kind
  localparam int unsigned KIND_BAD_BIT  = 0;
  localparam int unsigned KIND_GOOD_BIT = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/xor_result_monitor.sv
// Collects bad/good flags over a run of vectors and captures the first failure.
module xor_result_monitor
  import xor_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned IDX_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_vectors,
  input  logic             in_valid,
  input  logic [63:0]      x,
  input  logic             badness,
  input  logic             goodness,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] vec_count,
  output logic [CNT_W-1:0] bad_count,
  output logic [CNT_W-1:0] good_count,
  output logic             first_fail_valid,
  output logic [63:0]      first_fail_x,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [1:0]       first_fail_kind
);

  mon_state_t       state, state_next;
  logic [IDX_W-1:0] num_lat;
  logic             start_ok;
  logic             accept;
  logic             last_accept;
  logic             capture;

  // start is honoured only outside RUN; in_valid only inside RUN
  assign start_ok = start && (state != ST_RUN);
  assign accept   = (state == ST_RUN) && in_valid;
  // Compare against num_lat-1 so a full-range vector count cannot overflow
  assign last_accept = accept && (vec_count == (num_lat - 1'b1));
  assign capture     = accept && (badness || goodness) && !first_fail_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = (num_vectors != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (last_accept) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state and counts
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
    pass = (state == ST_DONE) && (bad_count == '0) && (good_count == '0);
  end

  // Run length latch, vector index and first-failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      num_lat          <= '0;
      vec_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_x     <= '0;
      first_fail_idx   <= '0;
      first_fail_kind  <= '0;
    end else if (start_ok) begin
      num_lat          <= num_vectors;
      vec_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_x     <= '0;
      first_fail_idx   <= '0;
      first_fail_kind  <= '0;
    end else begin
      if (accept) begin
        vec_count <= vec_count + 1'b1;
      end
      if (capture) begin
        first_fail_valid                <= 1'b1;
        first_fail_x                    <= x;
        first_fail_idx                  <= vec_count;
        first_fail_kind[KIND_BAD_BIT]   <= badness;
        first_fail_kind[KIND_GOOD_BIT]  <= goodness;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_bad_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .inc   (accept && badness),
    .count (bad_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_good_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .inc   (accept && goodness),
    .count (good_count)
  );

endmodule
